// File: rtl/rob_tail_alloc_pkg.sv
// Shared ROB sizing, pointer type and modulo-RENTRIES pointer add.
// Used by rob_tail_alloc, including the ROB_TAIL_RESTORE_EN build option.
package rob_tail_alloc_pkg;
  localparam int RENTRIES = 16;
  localparam int RSLOTS   = 2;
  localparam int RBIT     = $clog2(RENTRIES);
  localparam int CBIT     = $clog2(RENTRIES + 1);
  // Wide enough for ptr+RENTRIES and for the 4-bit retire amount.
  localparam int WBIT     = (CBIT + 1 > 4) ? CBIT + 1 : 4;

  typedef logic [RBIT-1:0] rob_ptr_t;
  typedef logic [WBIT-1:0] rob_wide_t;

  // n must not exceed RENTRIES; one conditional subtract then suffices.
  function automatic rob_ptr_t rob_add(rob_ptr_t ptr, rob_wide_t n);
    rob_wide_t sum;
    sum = rob_wide_t'(ptr) + n;
    if (sum >= rob_wide_t'(RENTRIES)) sum = sum - rob_wide_t'(RENTRIES);
    return rob_ptr_t'(sum);
  endfunction
endpackage

// File: rtl/rob_tail_alloc_prefix_count.sv
// Accepts the leading run of ready requests from slot 0 and counts it;
// flags request patterns with a hole (non-prefix).
module rob_prefix_count #(
  parameter int N  = 2,
  parameter int NW = $clog2(N + 1)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  rdy,
  output logic [N-1:0]  acc,
  output logic [NW-1:0] nacc,
  output logic          gap
);
  always_comb begin
    logic run;
    logic seen_zero;
    acc       = '0;
    nacc      = '0;
    gap       = 1'b0;
    run       = 1'b1;
    seen_zero = 1'b0;
    for (int i = 0; i < N; i++) begin
      run    = run & req[i] & rdy[i];
      acc[i] = run;
      if (run) nacc = nacc + NW'(1);
      if (req[i] && seen_zero) gap = 1'b1;
      if (!req[i]) seen_zero = 1'b1;
    end
  end
endmodule

// File: rtl/rob_tail_alloc.sv
// ROB tail allocator: owns head/tail/count, hands out consecutive slots.
// Define ROB_TAIL_RESTORE_EN to add the restore_i/restore_tail_i recovery port.
module rob_tail_alloc
  import rob_tail_alloc_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [RSLOTS-1:0]      alloc_v_i,
  input  logic [3:0]             ret_amt_i,
  input  logic                   flush_i,
`ifdef ROB_TAIL_RESTORE_EN
  input  logic                   restore_i,
  input  logic [RBIT-1:0]        restore_tail_i,
`endif
  output logic [RSLOTS-1:0]      alloc_rdy_o,
  output logic [RSLOTS*RBIT-1:0] rob_tails_o,
  output logic [RBIT-1:0]        rob_head_o,
  output logic [RENTRIES-1:0]    alloc_mask_o,
  output logic [CBIT-1:0]        count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   err_o
);
  localparam int NW = $clog2(RSLOTS + 1);

  rob_ptr_t        head_q, tail_q, head_next, tail_next;
  logic [CBIT-1:0] count_q;
  logic            full_q, empty_q, err_q;
  rob_ptr_t        tails [RSLOTS];
  rob_wide_t       cnt_w, free_w, ret_w, nret_w, nacc_w, cnt_next_w;
  logic [RSLOTS-1:0] acc;
  logic [NW-1:0]   nacc;
  logic            gap, overrun, blocked;

`ifdef ROB_TAIL_RESTORE_EN
  assign blocked = flush_i | restore_i;
`else
  assign blocked = flush_i;
`endif

  assign cnt_w   = rob_wide_t'(count_q);
  assign free_w  = rob_wide_t'(RENTRIES) - cnt_w;
  assign ret_w   = rob_wide_t'(ret_amt_i);
  assign overrun = ret_w > cnt_w;
  assign nret_w  = overrun ? cnt_w : ret_w;
  assign nacc_w  = rob_wide_t'(nacc);

  always_comb begin
    tails       = '{default: '0};
    alloc_rdy_o = '0;
    for (int i = 0; i < RSLOTS; i++) begin
      tails[i]       = rob_add(tail_q, rob_wide_t'(i));
      alloc_rdy_o[i] = (free_w > rob_wide_t'(i)) && !blocked;
    end
  end

  for (genvar g = 0; g < RSLOTS; g++) begin : g_tails
    assign rob_tails_o[g*RBIT +: RBIT] = tails[g];
  end

  rob_prefix_count #(.N(RSLOTS), .NW(NW)) u_prefix (
    .req  (alloc_v_i),
    .rdy  (alloc_rdy_o),
    .acc  (acc),
    .nacc (nacc),
    .gap  (gap)
  );

  always_comb begin
    alloc_mask_o = '0;
    for (int i = 0; i < RSLOTS; i++)
      if (acc[i]) alloc_mask_o[tails[i]] = 1'b1;
  end

  always_comb begin
    head_next  = rob_add(head_q, nret_w);
    tail_next  = rob_add(tail_q, nacc_w);
    cnt_next_w = cnt_w - nret_w + nacc_w;
    if (flush_i) begin
      tail_next  = head_next;
      cnt_next_w = '0;
    end
`ifdef ROB_TAIL_RESTORE_EN
    else if (restore_i) begin
      // Distance from new head to restored tail; equal pointers mean empty.
      tail_next  = restore_tail_i;
      cnt_next_w = rob_wide_t'(restore_tail_i) + rob_wide_t'(RENTRIES)
                   - rob_wide_t'(head_next);
      if (cnt_next_w >= rob_wide_t'(RENTRIES))
        cnt_next_w = cnt_next_w - rob_wide_t'(RENTRIES);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_next;
      tail_q  <= tail_next;
      count_q <= cnt_next_w[CBIT-1:0];
      full_q  <= (cnt_next_w == rob_wide_t'(RENTRIES));
      empty_q <= (cnt_next_w == '0);
      err_q   <= overrun | gap;
    end
  end

  assign rob_head_o = head_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_rob_tail_alloc.sv
// Scoreboard bench for rob_tail_alloc against an integer ROB model;
// also covers ROB_TAIL_RESTORE_EN when that macro is defined.
module tb_rob_tail_alloc;
  import rob_tail_alloc_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [RSLOTS-1:0]      alloc_v = '0;
  logic [3:0]             ret_amt = '0;
  logic                   flush = 1'b0;
`ifdef ROB_TAIL_RESTORE_EN
  logic                   restore = 1'b0;
  logic [RBIT-1:0]        restore_tail = '0;
`endif
  logic [RSLOTS-1:0]      rdy;
  logic [RSLOTS*RBIT-1:0] tails;
  logic [RBIT-1:0]        head;
  logic [RENTRIES-1:0]    mask;
  logic [CBIT-1:0]        count;
  logic                   full, empty, err;

  always #5 clk = ~clk;

  rob_tail_alloc dut (
    .clk_i(clk), .rst_ni(rst_n), .alloc_v_i(alloc_v), .ret_amt_i(ret_amt),
    .flush_i(flush),
`ifdef ROB_TAIL_RESTORE_EN
    .restore_i(restore), .restore_tail_i(restore_tail),
`endif
    .alloc_rdy_o(rdy), .rob_tails_o(tails), .rob_head_o(head),
    .alloc_mask_o(mask), .count_o(count), .full_o(full), .empty_o(empty),
    .err_o(err)
  );

  typedef struct {
    logic [RSLOTS-1:0]      rdy;
    logic [RSLOTS*RBIT-1:0] tails;
    int                     head;
    logic [RENTRIES-1:0]    mask;
    int                     count;
    bit                     full, empty, err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   m_head = 0, m_tail = 0, m_count = 0;
  bit   m_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ROB as head/tail/count integers with plain modulo arithmetic.
  task automatic step(input logic [RSLOTS-1:0] v, input int r, input bit f,
                      input bit rs, input int rt, input bit in_rst);
    exp_t e;
    int free, nacc, nret, vi;
    bit nonprefix;
    if (in_rst) begin
      m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
    end
    free = RENTRIES - m_count;
    e.rdy = '0; e.tails = '0; e.mask = '0;
    nacc = 0;
    for (int i = 0; i < RSLOTS; i++) begin
      e.rdy[i] = (free > i) && !f && !rs;
      e.tails[i*RBIT +: RBIT] = rob_ptr_t'((m_tail + i) % RENTRIES);
      if (v[i] && e.rdy[i] && nacc == i) nacc++;
    end
    for (int i = 0; i < nacc; i++) e.mask[(m_tail + i) % RENTRIES] = 1'b1;
    e.head = m_head; e.count = m_count;
    e.full = (m_count == RENTRIES); e.empty = (m_count == 0); e.err = m_err;
    q.push_back(e);
    if (in_rst) return;
    vi = int'(v);
    nonprefix = ((vi + 1) & vi) != 0;
    nret = (r < m_count) ? r : m_count;
    m_err = nonprefix || (r > m_count);
    m_head = (m_head + nret) % RENTRIES;
    if (f) begin
      m_tail = m_head; m_count = 0;
    end else if (rs) begin
      m_tail = rt; m_count = (rt - m_head + RENTRIES) % RENTRIES;
    end else begin
      m_tail = (m_tail + nacc) % RENTRIES;
      m_count = m_count - nret + nacc;
    end
  endtask

  task automatic drive(input logic [RSLOTS-1:0] v, input int r, input bit f,
                       input bit rs, input int rt);
    @(posedge clk); #1;
    rst_n = 1'b1; alloc_v = v; ret_amt = 4'(r); flush = f;
`ifdef ROB_TAIL_RESTORE_EN
    restore = rs; restore_tail = rob_ptr_t'(rt);
    step(v, r, f, rs, rt, 1'b0);
`else
    step(v, r, f, 1'b0, rt, 1'b0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; alloc_v = '0; ret_amt = '0; flush = 1'b0;
`ifdef ROB_TAIL_RESTORE_EN
    restore = 1'b0; restore_tail = '0;
`endif
    step('0, 0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("alloc_rdy", rdy, e.rdy);
        check("rob_tails", tails, e.tails);
        check("rob_head", head, e.head);
        check("alloc_mask", mask, e.mask);
        check("count", count, e.count);
        check("full", full, e.full);
        check("empty", empty, e.empty);
        check("err", err, e.err);
      end
    end
  end

  initial begin : stim
    logic [RSLOTS-1:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) drive('1, 0, 0, 0, 0);
    drive('1, 0, 0, 0, 0);
    drive('1, 3, 0, 0, 0);
    drive('1, 0, 0, 0, 0);
    drive('1, 0, 0, 0, 0);
    drive(RSLOTS'(2), 0, 0, 0, 0);
    drive('0, 0, 0, 0, 0);
    // head=5, count=6, then flush with a concurrent retire of 2
    do_reset();
    drive('1, 0, 0, 0, 0); drive('1, 0, 0, 0, 0); drive(RSLOTS'(1), 0, 0, 0, 0);
    drive('0, 5, 0, 0, 0);
    drive('1, 0, 0, 0, 0); drive('1, 0, 0, 0, 0); drive('1, 0, 0, 0, 0);
    drive('1, 2, 1, 0, 0);
    drive('1, 0, 0, 0, 0);
    drive('0, 4, 0, 0, 0);
    drive('0, 0, 0, 0, 0);
`ifdef ROB_TAIL_RESTORE_EN
    do_reset();
    for (int i = 0; i < 5; i++) drive('1, 0, 0, 0, 0);
    drive('0, 4, 0, 0, 0);
    drive('1, 0, 0, 1, 9);
    drive('0, 0, 0, 0, 0);
`endif
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        v = ($urandom_range(0, 3) != 0) ? '1 : RSLOTS'($urandom);
        drive(v,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1)),
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 19) == 0,
              int'($urandom_range(0, RENTRIES - 1)));
      end
    end
    @(posedge clk); #1;
    alloc_v = '0; ret_amt = '0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_tail_alloc.md
Name: rob_tail_alloc

Overview:
Tail-side allocator for the reorder buffer; the counterpart of the head-side retire-amount logic.
- Owns the registered head pointer, tail pointer and occupancy count.
- Hands out consecutive ROB slots to up to RSLOTS dispatching instructions per cycle.
- Advances head by the retire amount supplied by the retire logic.
- Sits between the dispatch stage and the ROB valid/entry arrays.

Parameters:
RENTRIES, 16, number of ROB entries; any value ≥ RSLOTS+1, need not be a power of 2
RSLOTS, 2, dispatch slots per cycle (1..4)
RBIT, $clog2(RENTRIES), pointer width
CBIT, $clog2(RENTRIES+1), count width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
alloc_v_i  in  RSLOTS  dispatch requests; slot i wants an entry
ret_amt_i  in  4  entries retired this cycle
flush_i  in  1  discard all in-flight entries
alloc_rdy_o  out  RSLOTS  slot i may allocate this cycle
rob_tails_o  out  RSLOTS×RBIT  entry index offered to slot i
rob_head_o  out  RBIT  current head pointer
alloc_mask_o  out  RENTRIES  one-hot set of entries allocated this cycle
count_o  out  CBIT  occupied entries
full_o  out  1  count == RENTRIES
empty_o  out  1  count == 0
err_o  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset values: head=0, tail=0, count=0, full_o=0, empty_o=1, err_o=0.
- Pointer outputs are registered state; rob_tails_o[i] = (tail+i) mod RENTRIES, combinational from tail.
- Free space: free = RENTRIES−count, using registered count only. There is no same-cycle credit from retire.
- alloc_rdy_o[i] = (free > i) && !flush_i.
- Accepted slots: acc = alloc_v_i & alloc_rdy_o. The request must be a prefix pattern (1, 11, …).
  - On a non-prefix request, only the leading contiguous run from slot 0 is accepted, and err_o pulses.
  - nacc = number of accepted slots.
- alloc_mask_o sets bit rob_tails_o[i] for each accepted i; zero when nacc=0. Purely combinational.
- Retire: nret = min(ret_amt_i, count). If ret_amt_i > count, err_o pulses next cycle.
- Next state, normal cycle:
  - head += nret mod RENTRIES
  - tail += nacc mod RENTRIES
  - count = count − nret + nacc
  - Simultaneous retire and allocate are both applied. Modulo arithmetic is done at CBIT+1 width, with no power-of-2 assumption.
- Flush cycle:
  - Retire still applies (head += nret).
  - tail = new head, count = 0. Allocation is blocked because alloc_rdy_o = 0.
- full_o and empty_o are registered, updated together with count.
- Wrap: head and tail pass RENTRIES−1 → 0. When head == tail, full and empty are distinguished by count.
- Reset asserted mid-operation clears all state immediately; the first allocation after release gets entry 0.
- Latency: allocation is visible in count_o and rob_tails_o on the next edge.

Optional Feature:
ROB_TAIL_RESTORE_EN
- With the macro: adds ports restore_i (in, 1) and restore_tail_i (in, RBIT).
  - On restore_i: tail = restore_tail_i; count = (restore_tail_i − new head) mod RENTRIES, with 0 meaning empty.
  - Allocation in that cycle is blocked.
  - flush_i has priority over restore_i.
- Without the macro: the ports are absent; the only recovery is a full flush.

Decomposition:
- Shared package: RENTRIES, RSLOTS, RBIT, CBIT, and a typedef rob_ptr_t (logic [RBIT-1:0]).
- Shared package: function rob_add(ptr, n), modulo-RENTRIES add, shared with the retire-amount logic.
- One sub-module, rob_prefix_count: prefix-mask and popcount of accepted slots, also reusable by dispatch.

Test Plan (RENTRIES=16, RSLOTS=2):
- Reset, then alloc_v=11 for 8 cycles → rob_tails 0/1, 2/3, …, 14/15. Count 16, full_o=1, alloc_rdy=00, tail=0.
- From full, ret_amt=3 with alloc_v=11 → this cycle nothing is allocated. Next cycle count 13, head 3, then 2 allocations succeed at entries 0/1.
- count=15, alloc_v=11 → alloc_rdy=01; only entry at tail is allocated (alloc_mask one bit); count 16.
- alloc_v=10 (non-prefix) → no allocation, err_o=1 one cycle, count unchanged.
- head=5, count=6, flush_i=1 with ret_amt=2 → head 7, tail 7, count 0, empty_o=1.
- ret_amt=4 with count=2 → head += 2, count 0, err_o pulses. With ROB_TAIL_RESTORE_EN: head=4, restore_tail=9 → count 5.
